// File: rtl/mips_multicycle_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_LUI = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        DST_RT  = 2'd0,
        DST_RD  = 2'd1,
        DST_R31 = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        SRCB_RT   = 2'd0,
        SRCB_SEXT = 2'd1,
        SRCB_ZEXT = 2'd2
    } src_b_t;

    // Coarse instruction class; selects the path through EXEC/MEM/WB
    typedef enum logic [3:0] {
        CL_RALU = 4'd0,
        CL_IALU = 4'd1,
        CL_LW   = 4'd2,
        CL_SW   = 4'd3,
        CL_BEQ  = 4'd4,
        CL_BNE  = 4'd5,
        CL_J    = 4'd6,
        CL_JAL  = 4'd7,
        CL_JR   = 4'd8
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        alu_op_t      alu_op;
        src_b_t       alu_src_b;
        logic         legal;
    } dec_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose: instruction/data memory request bus between sequencer and memory.
// Latency: n/a (signal bundle).
// Backpressure: mem_req is held until mem_ready acknowledges it.
interface mips_multicycle_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (output mem_req, output mem_we, input mem_rdata, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_rdata, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl_decode.sv
// Purpose: classify an IR opcode/funct pair and pick its ALU operation and B operand.
// Latency: purely combinational.
// Backpressure: none.
module mips_main_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Opcode/funct table; anything not listed is flagged illegal
    always_comb begin
        dec = '{cls: CL_RALU, alu_op: ALU_ADD, alu_src_b: SRCB_RT, legal: 1'b1};
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL:  dec.alu_op = ALU_SLL;
                    FN_SRL:  dec.alu_op = ALU_SRL;
                    FN_JR:   dec.cls    = CL_JR;
                    default: dec.legal  = 1'b0;
                endcase
            end
            OP_LW: begin
                dec.cls       = CL_LW;
                dec.alu_src_b = SRCB_SEXT;
            end
            OP_SW: begin
                dec.cls       = CL_SW;
                dec.alu_src_b = SRCB_SEXT;
            end
            OP_BEQ: begin
                dec.cls    = CL_BEQ;
                dec.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                dec.cls    = CL_BNE;
                dec.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                dec.cls       = CL_IALU;
                dec.alu_src_b = SRCB_SEXT;
            end
            OP_SLTI: begin
                dec.cls       = CL_IALU;
                dec.alu_op    = ALU_SLT;
                dec.alu_src_b = SRCB_SEXT;
            end
            OP_ANDI: begin
                dec.cls       = CL_IALU;
                dec.alu_op    = ALU_AND;
                dec.alu_src_b = SRCB_ZEXT;
            end
            OP_ORI: begin
                dec.cls       = CL_IALU;
                dec.alu_op    = ALU_OR;
                dec.alu_src_b = SRCB_ZEXT;
            end
            OP_LUI: begin
                dec.cls       = CL_IALU;
                dec.alu_op    = ALU_LUI;
                dec.alu_src_b = SRCB_ZEXT;
            end
            OP_J:    dec.cls   = CL_J;
            OP_JAL:  dec.cls   = CL_JAL;
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving shared datapath strobes.
// Latency: branch/jump 3, ALU/sw 4, lw 5 cycles with zero memory wait.
// Backpressure: stalls in FETCH/MEM until mem_ready; WAIT_LIMIT unacked cycles abort to FETCH.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mips_multicycle_ctrl_if.master     mem,
    input  logic                       alu_zero,
    output logic [5:0]                 ir_opcode,
    output logic [4:0]                 ir_rs,
    output logic [4:0]                 ir_rt,
    output logic [4:0]                 ir_rd,
    output logic [4:0]                 ir_shamt,
    output logic [5:0]                 ir_funct,
    output logic [15:0]                ir_imm16,
    output logic [25:0]                ir_target,
    output logic                       pc_we,
    output logic [1:0]                 pc_src,
    output logic [2:0]                 alu_op,
    output logic [1:0]                 alu_src_b,
    output logic                       reg_we,
    output logic [1:0]                 reg_dst,
    output logic [1:0]                 wb_sel,
    output logic                       instr_done,
    output logic                       illegal,
    output logic                       bus_error,
    output logic [2:0]                 state
);

    // Timeout fires in the cycle the counter would reach WAIT_LIMIT
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ir_q;
    logic [7:0]  wait_cnt_q;
    dec_t        dec;
    logic        mem_req_c;
    logic        mem_wait;
    logic        timeout;
    logic        ir_load;

    mips_main_decode u_decode (
        .opcode (ir_q[31:26]),
        .funct  (ir_q[5:0]),
        .dec    (dec)
    );

    // Request is a pure function of state, suppressed while reset is asserted
    assign mem_req_c = rst_n && (state_q == ST_FETCH || state_q == ST_MEM);
    assign mem_wait  = mem_req_c && !mem.mem_ready;
    assign timeout   = mem_wait && (wait_cnt_q == WAIT_LAST);
    assign ir_load   = (state_q == ST_FETCH) && mem.mem_ready;

    assign ir_opcode = ir_q[31:26];
    assign ir_rs     = ir_q[25:21];
    assign ir_rt     = ir_q[20:16];
    assign ir_rd     = ir_q[15:11];
    assign ir_shamt  = ir_q[10:6];
    assign ir_funct  = ir_q[5:0];
    assign ir_imm16  = ir_q[15:0];
    assign ir_target = ir_q[25:0];
    assign state     = state_q;

    // State register, instruction register and memory wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            ir_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= mem.mem_rdata;
            end
            if (mem_wait && !timeout) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem.mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                case (dec.cls)
                    CL_RALU, CL_IALU: state_d = ST_WB;
                    CL_LW, CL_SW:     state_d = ST_MEM;
                    default:          state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (timeout) begin
                    state_d = ST_FETCH;
                end else if (mem.mem_ready) begin
                    state_d = (dec.cls == CL_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath strobes, all held low while reset is asserted
    always_comb begin
        mem.mem_req = mem_req_c;
        mem.mem_we  = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SEQ;
        alu_op      = ALU_ADD;
        alu_src_b   = SRCB_RT;
        reg_we      = 1'b0;
        reg_dst     = DST_RT;
        wb_sel      = WB_ALU;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        bus_error   = timeout;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    pc_we = mem.mem_ready;
                end
                ST_DECODE: begin
                    illegal = !dec.legal;
                end
                ST_EXEC: begin
                    alu_op    = dec.alu_op;
                    alu_src_b = dec.alu_src_b;
                    case (dec.cls)
                        CL_BEQ: begin
                            pc_src     = PC_BRANCH;
                            pc_we      = alu_zero;
                            instr_done = 1'b1;
                        end
                        CL_BNE: begin
                            pc_src     = PC_BRANCH;
                            pc_we      = !alu_zero;
                            instr_done = 1'b1;
                        end
                        CL_J: begin
                            pc_src     = PC_JUMP;
                            pc_we      = 1'b1;
                            instr_done = 1'b1;
                        end
                        CL_JAL: begin
                            pc_src     = PC_JUMP;
                            pc_we      = 1'b1;
                            reg_we     = 1'b1;
                            reg_dst    = DST_R31;
                            wb_sel     = WB_PC;
                            instr_done = 1'b1;
                        end
                        CL_JR: begin
                            pc_src     = PC_REG;
                            pc_we      = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem.mem_we = (dec.cls == CL_SW);
                    instr_done = (dec.cls == CL_SW) && mem.mem_ready;
                end
                ST_WB: begin
                    // Keep the ALU operands stable so an unregistered result is still valid
                    alu_op     = dec.alu_op;
                    alu_src_b  = dec.alu_src_b;
                    reg_we     = 1'b1;
                    reg_dst    = (dec.cls == CL_RALU) ? DST_RD : DST_RT;
                    wb_sel     = (dec.cls == CL_LW) ? WB_MEM : WB_ALU;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: directed self-checking bench for the multi-cycle control sequencer.
// Latency: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: memory acknowledge is driven per cycle by the stimulus.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_zero;
    logic [5:0]  ir_opcode;
    logic [4:0]  ir_rs;
    logic [4:0]  ir_rt;
    logic [4:0]  ir_rd;
    logic [4:0]  ir_shamt;
    logic [5:0]  ir_funct;
    logic [15:0] ir_imm16;
    logic [25:0] ir_target;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src_b;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;
    logic        instr_done;
    logic        illegal;
    logic        bus_error;
    logic [2:0]  st;

    int n_checks = 0;
    int n_errors = 0;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .alu_zero   (alu_zero),
        .ir_opcode  (ir_opcode),
        .ir_rs      (ir_rs),
        .ir_rt      (ir_rt),
        .ir_rd      (ir_rd),
        .ir_shamt   (ir_shamt),
        .ir_funct   (ir_funct),
        .ir_imm16   (ir_imm16),
        .ir_target  (ir_target),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .alu_src_b  (alu_src_b),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .wb_sel     (wb_sel),
        .instr_done (instr_done),
        .illegal    (illegal),
        .bus_error  (bus_error),
        .state      (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One FETCH cycle with an immediate acknowledge
    task automatic fetch(input logic [31:0] word);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = word;
        @(negedge clk);
        chk("fetch state", 32'(st), 32'd0);
        chk("fetch mem_req", 32'(bus.mem_req), 32'd1);
        chk("fetch pc_we", 32'(pc_we), 32'd1);
        chk("fetch pc_src", 32'(pc_src), 32'd0);
        tick();
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        int mem_req_cycles;
        rst_n         = 1'b0;
        alu_zero      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;

        // Reset: strobes forced low even with a stray acknowledge
        repeat (2) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("rst state", 32'(st), 32'd0);
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst pc_we", 32'(pc_we), 32'd0);
        chk("rst ir_target", 32'(ir_target), 32'd0);
        chk("rst ir_opcode", 32'(ir_opcode), 32'd0);
        tick();
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;

        // add $3,$1,$2 : FETCH DECODE EXEC WB
        fetch(32'h00221820);
        bus.mem_ready = 1'b1;  // no request in DECODE, must be ignored
        @(negedge clk);
        chk("add dec state", 32'(st), 32'd1);
        chk("add rs", 32'(ir_rs), 32'd1);
        chk("add rt", 32'(ir_rt), 32'd2);
        chk("add rd", 32'(ir_rd), 32'd3);
        chk("add funct", 32'(ir_funct), 32'h20);
        chk("add dec pc_we", 32'(pc_we), 32'd0);
        chk("add dec illegal", 32'(illegal), 32'd0);
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("add exec state", 32'(st), 32'd2);
        chk("add alu_op", 32'(alu_op), 32'd0);
        chk("add alu_src_b", 32'(alu_src_b), 32'd0);
        chk("add exec reg_we", 32'(reg_we), 32'd0);
        tick();
        @(negedge clk);
        chk("add wb state", 32'(st), 32'd4);
        chk("add reg_we", 32'(reg_we), 32'd1);
        chk("add reg_dst", 32'(reg_dst), 32'd1);
        chk("add wb_sel", 32'(wb_sel), 32'd0);
        chk("add done", 32'(instr_done), 32'd1);
        tick();

        // lw $5,8($4) with three wait cycles in MEM
        fetch(32'h8C850008);
        @(negedge clk);
        chk("lw imm16", 32'(ir_imm16), 32'h0008);
        chk("lw opcode", 32'(ir_opcode), 32'h23);
        tick();
        @(negedge clk);
        chk("lw alu_src_b", 32'(alu_src_b), 32'd1);
        chk("lw alu_op", 32'(alu_op), 32'd0);
        tick();
        mem_req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            @(negedge clk);
            chk("lw mem state", 32'(st), 32'd3);
            chk("lw mem_we", 32'(bus.mem_we), 32'd0);
            chk("lw mem done", 32'(instr_done), 32'd0);
            if (bus.mem_req) mem_req_cycles++;
            tick();
        end
        bus.mem_ready = 1'b0;
        chk("lw mem_req cycles", 32'(mem_req_cycles), 32'd4);
        @(negedge clk);
        chk("lw wb state", 32'(st), 32'd4);
        chk("lw reg_dst", 32'(reg_dst), 32'd0);
        chk("lw wb_sel", 32'(wb_sel), 32'd1);
        chk("lw done", 32'(instr_done), 32'd1);
        tick();

        // beq taken, beq not taken, bne taken
        fetch(32'h10220004);
        tick();
        alu_zero = 1'b1;
        @(negedge clk);
        chk("beq1 alu_op", 32'(alu_op), 32'd1);
        chk("beq1 pc_src", 32'(pc_src), 32'd1);
        chk("beq1 pc_we", 32'(pc_we), 32'd1);
        chk("beq1 done", 32'(instr_done), 32'd1);
        tick();
        fetch(32'h10220004);
        tick();
        alu_zero = 1'b0;
        @(negedge clk);
        chk("beq0 pc_we", 32'(pc_we), 32'd0);
        chk("beq0 done", 32'(instr_done), 32'd1);
        tick();
        fetch(32'h14220004);
        tick();
        @(negedge clk);
        chk("bne pc_we", 32'(pc_we), 32'd1);
        chk("bne pc_src", 32'(pc_src), 32'd1);
        tick();

        // jal 0x100, then jr $31
        fetch(32'h0C000100);
        @(negedge clk);
        chk("jal target", 32'(ir_target), 32'h0000100);
        tick();
        @(negedge clk);
        chk("jal pc_we", 32'(pc_we), 32'd1);
        chk("jal pc_src", 32'(pc_src), 32'd2);
        chk("jal reg_we", 32'(reg_we), 32'd1);
        chk("jal reg_dst", 32'(reg_dst), 32'd2);
        chk("jal wb_sel", 32'(wb_sel), 32'd2);
        chk("jal done", 32'(instr_done), 32'd1);
        tick();
        fetch(32'h03E00008);
        tick();
        @(negedge clk);
        chk("jr pc_src", 32'(pc_src), 32'd3);
        chk("jr pc_we", 32'(pc_we), 32'd1);
        chk("jr reg_we", 32'(reg_we), 32'd0);
        tick();

        // ori $2,$1,5 : zero-extended immediate, writes rt
        fetch(32'h34220005);
        tick();
        @(negedge clk);
        chk("ori alu_op", 32'(alu_op), 32'd3);
        chk("ori alu_src_b", 32'(alu_src_b), 32'd2);
        tick();
        @(negedge clk);
        chk("ori reg_we", 32'(reg_we), 32'd1);
        chk("ori reg_dst", 32'(reg_dst), 32'd0);
        tick();

        // sw $5,8($4) with one wait cycle
        fetch(32'hAC850008);
        tick();
        tick();
        @(negedge clk);
        chk("sw mem_we", 32'(bus.mem_we), 32'd1);
        chk("sw wait done", 32'(instr_done), 32'd0);
        tick();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("sw done", 32'(instr_done), 32'd1);
        chk("sw reg_we", 32'(reg_we), 32'd0);
        tick();
        bus.mem_ready = 1'b0;

        // Illegal opcode and illegal funct
        fetch(32'hFC000000);
        @(negedge clk);
        chk("ill op illegal", 32'(illegal), 32'd1);
        chk("ill op reg_we", 32'(reg_we), 32'd0);
        chk("ill op mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        fetch(32'h00000001);
        @(negedge clk);
        chk("ill fn illegal", 32'(illegal), 32'd1);
        tick();

        // Fetch timeout after four unacknowledged cycles
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("to state", 32'(st), 32'd0);
            chk("to mem_req", 32'(bus.mem_req), 32'd1);
            chk("to pc_we", 32'(pc_we), 32'd0);
            chk("to bus_error", 32'(bus_error), (i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        @(negedge clk);
        chk("after to bus_error", 32'(bus_error), 32'd0);
        chk("after to state", 32'(st), 32'd0);
        chk("after to ir_funct", 32'(ir_funct), 32'h01);
        tick();

        // Reset asserted mid-EXEC abandons the instruction
        fetch(32'h00221820);
        tick();
        @(negedge clk);
        chk("pre-rst state", 32'(st), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst state", 32'(st), 32'd0);
        chk("mid-rst reg_we", 32'(reg_we), 32'd0);
        chk("mid-rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid-rst pc_we", 32'(pc_we), 32'd0);
        chk("mid-rst ir", 32'(ir_rd), 32'd0);
        tick();
        rst_n = 1'b1;
        fetch(32'h00221820);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the MIPS core. It fetches instruction words over a ready/valid memory handshake and latches them in an internal instruction register (IR). It splits the IR into opcode, rs, rt, rd, shamt, funct, imm16 and target26 fields for the datapath. It then steps through FETCH, DECODE, EXEC, MEM and WB, driving all datapath strobes, so that one ALU, one memory port and one register-file write port are shared across cycles.

Parameters:
WAIT_LIMIT, 255, maximum number of cycles a mem_req may remain unacknowledged before bus_error fires (8-bit counter).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
mem_rdata  in  32  instruction word from memory, sampled on a FETCH handshake
mem_ready  in  1  memory acknowledge for the current mem_req
alu_zero  in  1  ALU zero flag, valid in EXEC
mem_req  out  1  memory access request
mem_we  out  1  write qualifier for mem_req
ir_opcode/ir_rs/ir_rt/ir_rd/ir_shamt/ir_funct  out  6/5/5/5/5/6  latched IR fields
ir_imm16  out  16  IR[15:0]
ir_target  out  26  IR[25:0]
pc_we  out  1  PC load enable
pc_src  out  2  next-PC source: 0=PC+4, 1=branch, 2=jump, 3=register (jr)
alu_op  out  3  0=ADD 1=SUB 2=AND 3=OR 4=SLT 5=SLL 6=SRL 7=LUI
alu_src_b  out  2  ALU B operand: 0=rt, 1=sign-extended imm, 2=zero-extended imm
reg_we  out  1  register-file write enable
reg_dst  out  2  write destination: 0=rt, 1=rd, 2=r31
wb_sel  out  2  write-back data: 0=ALU, 1=memory, 2=PC (already PC+4)
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse on an unsupported encoding
bus_error  out  1  one-cycle pulse on a memory timeout
state  out  3  current state, for debug

Behaviour:
- Reset (rst_n low):
  - state=FETCH, IR=0, wait counter=0.
  - All strobes and pulse outputs are forced to 0 while rst_n is low.
  - First mem_req appears in the first cycle after rst_n is released.
- Outputs are Moore-decoded from the state and IR; the only exceptions are pc_we/ir load in FETCH (gated by mem_ready) and pc_we for branches (gated by alu_zero).
- FETCH:
  - mem_req=1, mem_we=0; hold until mem_ready.
  - On mem_ready: IR<=mem_rdata, pc_we=1, pc_src=0, then go to DECODE.
- DECODE: one cycle, no strobes.
  - Legal encoding: go to EXEC.
  - Otherwise: illegal=1, go to FETCH (PC has already advanced).
- Legal encodings:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02, jr 0x08.
  - lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A, lui 0x0F, j 0x02, jal 0x03.
- EXEC:
  - R-ALU / I-ALU: drive alu_op; alu_src_b=0 for R-type, 2 for andi/ori/lui, 1 otherwise; go to WB.
  - lw/sw: alu_op=ADD, alu_src_b=1, go to MEM.
  - beq/bne: alu_op=SUB, pc_src=1, pc_we=(beq&alu_zero)|(bne&!alu_zero); instr_done; go to FETCH.
  - j: pc_we=1, pc_src=2, instr_done, go to FETCH.
  - jal: as j, plus reg_we=1, reg_dst=2, wb_sel=2.
  - jr: pc_we=1, pc_src=3, instr_done, go to FETCH.
- MEM:
  - mem_req=1, mem_we=1 for sw; hold until mem_ready.
  - sw: instr_done, go to FETCH.
  - lw: go to WB.
- WB:
  - reg_we=1; reg_dst=1 for R-type, 0 for I-type; wb_sel=1 for lw, else 0.
  - instr_done; go to FETCH.
- Latency with zero memory wait: branch/jump 3 cycles, ALU/sw 4 cycles, lw 5 cycles.
- Wait counter:
  - Increments each cycle mem_req=1 && !mem_ready; clears on handshake or state change.
  - When the counter reaches WAIT_LIMIT: bus_error=1, counter cleared, IR unchanged, go to FETCH with no PC update.
  - A timeout in FETCH therefore refetches the same address.
- mem_ready with mem_req=0 is ignored.
- Asynchronous reset mid-instruction abandons the instruction; no partial strobes.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct localparams;
  - state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4;
  - alu_op, pc_src, reg_dst and wb_sel codes.
- One sub-module, mips_main_decode: combinational IR → {class, alu_op, alu_src_b, legal}, instantiated once.

Test Plan:
1. Reset, then mem_rdata=0x00221820 (add $3,$1,$2) with mem_ready=1 → states 0,1,2,4; pc_we in cycle 1; WB has reg_we=1, reg_dst=1, wb_sel=0, alu_op=0 (in EXEC); instr_done in cycle 4.
2. 0x8C850008 (lw $5,8($4)) with a 3-cycle MEM wait → ir_imm16=0x0008, alu_src_b=1, mem_req held for 4 cycles, WB has reg_dst=0, wb_sel=1; total 8 cycles.
3. 0x10220004 (beq) with alu_zero=1, then repeated with alu_zero=0 → pc_we=1/pc_src=1 then pc_we=0; instr_done both times; 3 cycles each.
4. 0x0C000100 (jal) → ir_target=0x0000100; EXEC has pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_sel=2.
5. 0xFC000000 (opcode 0x3F) → illegal pulses in DECODE, no reg_we/mem_req, FETCH next cycle.
6. mem_ready held low with WAIT_LIMIT=4 → bus_error pulses in cycle 4 of the wait, pc_we stays 0; asserting rst_n low mid-EXEC returns to FETCH with all strobes 0.
